// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures the half-period of a divided clock (in clk
// cycles). It flags a mismatch against an expected half-period, locks after
// LOCK_CNT consecutive correct half-periods, and detects a stalled divider.
//
// Ports:
//   clk          system clock; all logic updates on its rising edge
//   reset        synchronous active-high reset
//   i_en         monitor enable
//   i_div_clk    divided clock under test (generated from clk)
//   i_exp_half   expected half-period in clk cycles (2 .. 2^WIDTH-2)
//   o_rise       one-cycle pulse on a rising edge of i_div_clk
//   o_fall       one-cycle pulse on a falling edge of i_div_clk
//   o_len        last accepted half-period measurement
//   o_len_valid  o_len holds an unconsumed measurement
//   i_len_ready  consumer accepts o_len
//   o_locked     divided clock matches i_exp_half
//   o_err        sticky mismatch/timeout flag
//   o_overrun    sticky flag: a measurement was dropped (result register full)
//   o_err_cnt    saturating error count
`timescale 1ns/1ps
module div_clk_monitor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic [WIDTH-1:0] i_exp_half,
  output logic             o_rise,
  output logic             o_fall,
  output logic [WIDTH-1:0] o_len,
  output logic             o_len_valid,
  input  logic             i_len_ready,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_overrun,
  output logic [WIDTH-1:0] o_err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] LEN_MAX  = '1;
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCK} state_t;

  state_t           state;
  state_t           state_next;
  logic             d1;
  logic             d2;
  logic             edge_evt;
  logic [WIDTH-1:0] len_cnt;
  logic [WIDTH-1:0] len_next;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_next;
  logic             meas;
  logic             err_evt;

  // Edge pulses decode straight from the synchroniser flops.
  assign edge_evt = d1 ^ d2;
  assign o_rise   = d1 & ~d2;
  assign o_fall   = ~d1 & d2;
  assign o_locked = (state == LOCK);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, length counter, lock counter and event decode.
  always_comb begin
    state_next = state;
    len_next   = len_cnt;
    good_next  = good_cnt;
    meas       = 1'b0;
    err_evt    = 1'b0;
    if (!i_en) begin
      state_next = IDLE;
      len_next   = '0;
      good_next  = '0;
    end else begin
      unique case (state)
        IDLE: state_next = SYNC;
        SYNC: begin
          // First edge only aligns the counter; nothing is measured yet.
          if (edge_evt) begin
            state_next = MEAS;
            len_next   = WIDTH'(1);
          end
        end
        MEAS, LOCK: begin
          if (edge_evt) begin
            meas     = 1'b1;
            len_next = WIDTH'(1);
            if (len_cnt == i_exp_half) begin
              if (good_cnt != GOOD_MAX) good_next = good_cnt + GW'(1);
              if (good_next == GOOD_MAX) state_next = LOCK;
            end else begin
              err_evt    = 1'b1;
              good_next  = '0;
              state_next = MEAS;
            end
          end else if (len_cnt == LEN_MAX) begin
            // Divider stalled: counter would wrap, so resynchronise.
            err_evt    = 1'b1;
            good_next  = '0;
            len_next   = '0;
            state_next = SYNC;
          end else begin
            len_next = len_cnt + WIDTH'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers: synchroniser, counters, result register, error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1          <= 1'b0;
      d2          <= 1'b0;
      len_cnt     <= '0;
      good_cnt    <= '0;
      o_len       <= '0;
      o_len_valid <= 1'b0;
      o_err       <= 1'b0;
      o_overrun   <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      d1       <= i_div_clk;
      d2       <= d1;
      len_cnt  <= len_next;
      good_cnt <= good_next;

      if (err_evt) begin
        o_err <= 1'b1;
        if (o_err_cnt != LEN_MAX) o_err_cnt <= o_err_cnt + WIDTH'(1);
      end

      // One-deep result register; a new value may replace one being consumed.
      if (!i_en) begin
        o_len_valid <= 1'b0;
      end else if (meas) begin
        if (!o_len_valid || i_len_ready) begin
          o_len       <= len_cnt;
          o_len_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_len_ready) begin
        o_len_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor (WIDTH=8, LOCK_CNT=4).
`timescale 1ns/1ps
module tb_div_clk_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_en;
  logic       i_div_clk;
  logic [7:0] i_exp_half;
  logic       o_rise;
  logic       o_fall;
  logic [7:0] o_len;
  logic       o_len_valid;
  logic       i_len_ready;
  logic       o_locked;
  logic       o_err;
  logic       o_overrun;
  logic [7:0] o_err_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  div_clk_monitor #(.WIDTH(8), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_en       (i_en),
    .i_div_clk  (i_div_clk),
    .i_exp_half (i_exp_half),
    .o_rise     (o_rise),
    .o_fall     (o_fall),
    .o_len      (o_len),
    .o_len_valid(o_len_valid),
    .i_len_ready(i_len_ready),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_overrun  (o_overrun),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Toggle the divided clock, then hold it for n cycles.
  task automatic half(input int n);
    i_div_clk = ~i_div_clk;
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    i_en        = 1'b0;
    i_div_clk   = 1'b0;
    i_exp_half  = 8'd8;
    i_len_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("rst_rise",    32'(o_rise), 0);
    check("rst_fall",    32'(o_fall), 0);
    check("rst_locked",  32'(o_locked), 0);
    check("rst_len",     32'(o_len), 0);
    check("rst_valid",   32'(o_len_valid), 0);
    check("rst_err",     32'(o_err), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_errcnt",  32'(o_err_cnt), 0);

    // Lock on a steady half-period of 8
    i_en = 1'b1;
    step();
    i_div_clk = 1'b1;                 // sync edge, no measurement
    step();
    check("sync_rise_pulse", 32'(o_rise), 1);
    step();
    check("sync_rise_end", 32'(o_rise), 0);
    check("sync_no_valid", 32'(o_len_valid), 0);
    repeat (6) step();
    half(2);                          // capture #1
    check("cap1_valid", 32'(o_len_valid), 1);
    check("cap1_len", 32'(o_len), 8);
    repeat (6) step();
    half(8);                          // capture #2
    check("cap2_len", 32'(o_len), 8);
    half(8);                          // capture #3
    check("cap3_len", 32'(o_len), 8);
    check("cap3_unlocked", 32'(o_locked), 0);
    half(8);                          // capture #4
    check("cap4_len", 32'(o_len), 8);
    check("cap4_locked", 32'(o_locked), 1);
    check("cap4_no_err", 32'(o_err), 0);

    // One stretched half-period of 9 breaks lock, then relock
    half(9);                          // captures 8
    check("pre_stretch_locked", 32'(o_locked), 1);
    half(8);                          // captures 9
    check("stretch_len", 32'(o_len), 9);
    check("stretch_err", 32'(o_err), 1);
    check("stretch_errcnt", 32'(o_err_cnt), 1);
    check("stretch_unlocked", 32'(o_locked), 0);
    half(8);
    half(8);
    half(8);
    check("relock3_unlocked", 32'(o_locked), 0);
    half(8);
    check("relock4_locked", 32'(o_locked), 1);

    // Backpressure: hold, drop with overrun, then replace on a ready pulse
    i_len_ready = 1'b0;
    half(6);                          // captures 8
    check("bp_first_len", 32'(o_len), 8);
    check("bp_first_valid", 32'(o_len_valid), 1);
    check("bp_no_overrun", 32'(o_overrun), 0);
    i_exp_half = 8'd6;
    half(6);                          // captures 6, dropped
    check("bp_held_len", 32'(o_len), 8);
    check("bp_overrun", 32'(o_overrun), 1);
    i_div_clk = ~i_div_clk;
    step();
    i_len_ready = 1'b1;
    step();                           // capture with ready in the same cycle
    check("bp_replace_len", 32'(o_len), 6);
    check("bp_replace_valid", 32'(o_len_valid), 1);
    i_len_ready = 1'b0;
    repeat (3) step();
    check("bp_valid_held", 32'(o_len_valid), 1);
    i_len_ready = 1'b1;
    step();
    check("bp_valid_clear", 32'(o_len_valid), 0);
    check("bp_still_locked", 32'(o_locked), 1);
    check("bp_errcnt", 32'(o_err_cnt), 1);

    // Divider stuck high for 260 cycles -> timeout, resync
    i_div_clk = ~i_div_clk;           // rises
    step();
    check("to_rise", 32'(o_rise), 1);
    step();
    check("to_cap_len", 32'(o_len), 6);
    repeat (258) step();
    check("to_errcnt", 32'(o_err_cnt), 2);
    check("to_unlocked", 32'(o_locked), 0);
    check("to_err", 32'(o_err), 1);
    i_len_ready = 1'b0;
    i_exp_half  = 8'd8;
    half(8);                          // sync edge after timeout
    check("to_sync_no_valid", 32'(o_len_valid), 0);
    check("to_sync_errcnt", 32'(o_err_cnt), 2);
    half(8);
    check("to_meas_valid", 32'(o_len_valid), 1);
    check("to_meas_len", 32'(o_len), 8);

    // Reset in the middle of a measurement while o_err is set
    i_div_clk = ~i_div_clk;
    repeat (4) step();
    check("mid_err_set", 32'(o_err), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_rise",    32'(o_rise), 0);
    check("mr_fall",    32'(o_fall), 0);
    check("mr_locked",  32'(o_locked), 0);
    check("mr_len",     32'(o_len), 0);
    check("mr_valid",   32'(o_len_valid), 0);
    check("mr_err",     32'(o_err), 0);
    check("mr_overrun", 32'(o_overrun), 0);
    check("mr_errcnt",  32'(o_err_cnt), 0);

    // Build an error, then disable: state/valid clear, sticky values hold
    repeat (2) step();
    half(8);                          // sync edge
    half(5);                          // captures 8
    half(8);                          // captures 5, mismatch and dropped
    check("dis_pre_err", 32'(o_err), 1);
    check("dis_pre_errcnt", 32'(o_err_cnt), 1);
    check("dis_pre_overrun", 32'(o_overrun), 1);
    check("dis_pre_len", 32'(o_len), 8);
    i_en = 1'b0;
    step();
    check("dis_valid", 32'(o_len_valid), 0);
    check("dis_locked", 32'(o_locked), 0);
    check("dis_errcnt", 32'(o_err_cnt), 1);
    check("dis_err", 32'(o_err), 1);
    check("dis_overrun", 32'(o_overrun), 1);
    check("dis_len", 32'(o_len), 8);
    i_div_clk = ~i_div_clk;           // falls
    step();
    check("dis_fall_pulse", 32'(o_fall), 1);
    step();
    check("dis_fall_end", 32'(o_fall), 0);
    repeat (10) step();
    check("dis_idle_valid", 32'(o_len_valid), 0);
    check("dis_idle_errcnt", 32'(o_err_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the length counter, expected length, measured length and error count.
REQ-002 SHALL have parameter LOCK_CNT, default 4, the number of consecutive correct half-periods needed to lock.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_en, input, 1 bit: monitor enable.
REQ-006 SHALL have port i_div_clk, input, 1 bit: the divided clock from the upstream divider, generated from clk.
REQ-007 SHALL have port i_exp_half, input, WIDTH bits: expected half-period in clk cycles; legal range 2..2^WIDTH-2.
REQ-008 SHALL have port o_rise, output, 1 bit: one-cycle pulse marking a rising edge of i_div_clk.
REQ-009 SHALL have port o_fall, output, 1 bit: one-cycle pulse marking a falling edge of i_div_clk.
REQ-010 SHALL have port o_len, output, WIDTH bits: the last measured half-period length.
REQ-011 SHALL have port o_len_valid, output, 1 bit: o_len holds an unconsumed measurement.
REQ-012 SHALL have port i_len_ready, input, 1 bit: the consumer accepts o_len.
REQ-013 SHALL have port o_locked, output, 1 bit: the divided clock matches i_exp_half.
REQ-014 SHALL have port o_err, output, 1 bit: sticky flag for a mismatch or timeout.
REQ-015 SHALL have port o_overrun, output, 1 bit: sticky flag for a measurement dropped because the result register was full.
REQ-016 SHALL have port o_err_cnt, output, WIDTH bits: count of errors, saturating.

Function
REQ-017 SHALL register i_div_clk into d1, then d1 into d2; o_rise = d1 & ~d2, o_fall = ~d1 & d2 (edge event).
REQ-018 SHALL implement FSM states IDLE, SYNC, MEAS, LOCK.
REQ-019 SHALL move IDLE->SYNC when i_en=1; in SYNC the first edge event moves to MEAS, loads len_cnt=1 and produces no measurement.
REQ-020 SHALL, in MEAS/LOCK, increment len_cnt each cycle without an edge event; on an edge event, capture len_cnt as the measurement and reload len_cnt=1.
REQ-021 SHALL count a measurement equal to i_exp_half as correct: good_cnt increments, saturating at LOCK_CNT; MEAS->LOCK when good_cnt reaches LOCK_CNT.
REQ-022 SHALL treat a measurement not equal to i_exp_half as a mismatch: o_err<=1, o_err_cnt+1 (saturating at all-ones), good_cnt<=0, LOCK->MEAS, MEAS stays MEAS.
REQ-023 SHALL detect timeout when len_cnt reaches all-ones with no edge event: treat as an error (as REQ-022), go to SYNC, no measurement produced.
REQ-024 SHALL make o_locked=1 exactly while in LOCK.
REQ-025 SHALL keep a one-deep result register: a measurement loads o_len and sets o_len_valid when o_len_valid=0, or when i_len_ready=1 in the same cycle.
REQ-026 SHALL, when a measurement arrives with o_len_valid=1 and i_len_ready=0, drop the new value, keep o_len unchanged, and set o_overrun<=1.
REQ-027 SHALL clear o_len_valid when i_len_ready=1 and no measurement arrives; o_len SHALL hold while o_len_valid=1.
REQ-028 SHALL, when i_en=0, go to IDLE next cycle and clear len_cnt, good_cnt and o_len_valid; o_err, o_overrun, o_err_cnt and o_len hold; o_rise/o_fall continue.
REQ-029 SHALL let i_exp_half change at any time; each comparison uses the value present in the capture cycle.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, set d1, d2, len_cnt, good_cnt, o_len, o_len_valid, o_err, o_overrun and o_err_cnt to 0 and the state to IDLE; o_rise=o_fall=o_locked=0 the following cycle.
REQ-031 SHALL give reset priority over i_en, edges and handshake, including mid-measurement; the sticky flags clear only on reset.

Verification
REQ-032 SHALL verify: reset, i_en=1, i_exp_half=8, i_div_clk toggling every 8 clk, i_len_ready=1 -> o_len=8 per edge, o_locked=1 after the 4th correct capture, o_err=0.
REQ-033 SHALL verify: locked at 8, one half-period stretched to 9 -> o_err=1, o_err_cnt=1, o_locked=0 that cycle, relock after 4 further correct captures.
REQ-034 SHALL verify: i_len_ready=0 across two captures -> first value held, o_overrun=1; ready pulse plus capture in the same cycle -> new value loaded, o_len_valid stays 1.
REQ-035 SHALL verify: i_div_clk stuck high 260 cycles -> timeout, o_err_cnt+1, state SYNC, the next edge produces no o_len_valid.
REQ-036 SHALL verify: reset asserted mid-MEAS with o_err=1 -> all outputs 0 next cycle; i_en=0 -> IDLE, o_err_cnt held.
